// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared defaults, FSM states and counter-width helper for conv_linebuf
package conv_pkg;

    localparam int NB_PIX_DEF     = 8;
    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_line_ram.sv
// rtl/conv_line_ram.sv - one image line of storage, read-before-write at a single address
module conv_line_ram #(
    parameter int DEPTH = 640,
    parameter int NB    = 8,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [NB-1:0] wdata,
    output logic [NB-1:0] rdata
);

    logic [NB-1:0] mem [DEPTH];

    // Old content is visible for the whole cycle; the new pixel lands at the edge.
    assign rdata = mem[addr];

    // Write the incoming value at the clock edge when a pixel is accepted.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_linebuf.sv
// rtl/conv_linebuf.sv - 3-row line buffer emitting column triples for a 3x3 convolution (option: CONV_LINEBUF_TOP_PAD_EN)
module conv_linebuf
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int NB_PIX     = NB_PIX_DEF
) (
    input  logic              clk,
    input  logic              i_nrst,
    input  logic              i_sof,
    input  logic              i_valid,
    input  logic [NB_PIX-1:0] i_pixel,
    output logic [NB_PIX-1:0] o_data1,
    output logic [NB_PIX-1:0] o_data2,
    output logic [NB_PIX-1:0] o_data3,
    output logic              o_en_conv,
    output logic              o_win_valid,
    output logic              o_eof
);

    localparam int COL_W = cnt_w(IMG_WIDTH);
    localparam int ROW_W = cnt_w(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
`ifdef CONV_LINEBUF_TOP_PAD_EN
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
`endif

    state_t             state;
    state_t             state_nxt;
    logic [COL_W-1:0]   col;
    logic [COL_W-1:0]   col_nxt;
    logic [COL_W-1:0]   eff_col;
    logic [ROW_W-1:0]   row;
    logic [ROW_W-1:0]   row_nxt;
    logic [ROW_W-1:0]   eff_row;
    logic               accept;
    logic               emit;
    logic               frame_last;
    logic [NB_PIX-1:0]  line1_rd;
    logic [NB_PIX-1:0]  line2_rd;
    logic [NB_PIX-1:0]  tap1;
    logic [NB_PIX-1:0]  tap2;

    // Position bookkeeping, FSM transitions and emit decision for the current pixel.
    always_comb begin
        state_nxt  = state;
        col_nxt    = col;
        row_nxt    = row;
        // A start-of-frame pixel always lands at row 0 col 0, whatever the counters say.
        accept     = i_valid & (i_sof | (state != ST_IDLE));
        eff_col    = i_sof ? '0 : col;
        eff_row    = i_sof ? '0 : row;
        frame_last = (eff_col == COL_LAST) && (eff_row == ROW_LAST);
        if (accept) begin
            if (eff_col == COL_LAST) begin
                col_nxt = '0;
                row_nxt = (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
            end else begin
                col_nxt = eff_col + COL_W'(1);
                row_nxt = eff_row;
            end
            if (frame_last) begin
                state_nxt = ST_IDLE;
            end else if (i_sof) begin
                state_nxt = ST_FILL;
            end else if ((eff_col == COL_LAST) && (eff_row == ROW_ONE)) begin
                state_nxt = ST_STREAM;
            end
        end
`ifdef CONV_LINEBUF_TOP_PAD_EN
        // Rows 0 and 1 are emitted too; rows above the frame read as zero, never stale memory.
        emit = accept;
        tap1 = (eff_row >= ROW_TWO) ? line2_rd : '0;
        tap2 = (eff_row != '0) ? line1_rd : '0;
`else
        // Only rows that have two real rows above them are emitted.
        emit = accept & ~i_sof & (state == ST_STREAM);
        tap1 = line2_rd;
        tap2 = line1_rd;
`endif
    end

    // Line 1 holds row r-1; it shifts its old content into line 2 (row r-2).
    conv_line_ram #(
        .DEPTH (IMG_WIDTH),
        .NB    (NB_PIX),
        .AW    (COL_W)
    ) u_line1 (
        .clk   (clk),
        .we    (accept),
        .addr  (eff_col),
        .wdata (i_pixel),
        .rdata (line1_rd)
    );

    conv_line_ram #(
        .DEPTH (IMG_WIDTH),
        .NB    (NB_PIX),
        .AW    (COL_W)
    ) u_line2 (
        .clk   (clk),
        .we    (accept),
        .addr  (eff_col),
        .wdata (line1_rd),
        .rdata (line2_rd)
    );

    // FSM state and raster counters; idle input leaves everything untouched.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= ST_IDLE;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
        end
    end

    // Registered triple; data holds between emits, flags are single-cycle.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_data1     <= '0;
            o_data2     <= '0;
            o_data3     <= '0;
            o_en_conv   <= 1'b0;
            o_win_valid <= 1'b0;
            o_eof       <= 1'b0;
        end else begin
            o_en_conv   <= emit;
            o_win_valid <= emit & (eff_col >= COL_TWO);
            o_eof       <= emit & frame_last;
            if (emit) begin
                o_data1 <= tap1;
                o_data2 <= tap2;
                o_data3 <= i_pixel;
            end
        end
    end

endmodule

// File: doc/conv_linebuf.md
CONV_LINEBUF -- requirements
Module: conv_linebuf

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low; ports SHALL be named clk and i_nrst.
REQ-002 Parameter IMG_WIDTH, 640, pixels per image row (range 4..1024).
REQ-003 Parameter IMG_HEIGHT, 480, rows per frame (range 3..1024).
REQ-004 Parameter NB_PIX, 8, pixel width in bits.
REQ-005 clk  in  1  100 MHz clock.
REQ-006 i_nrst  in  1  async active-low reset.
REQ-007 i_sof  in  1  start-of-frame; qualifies the pixel presented with i_valid in the same cycle.
REQ-008 i_valid  in  1  i_pixel valid this cycle.
REQ-009 i_pixel  in  NB_PIX  signed raster-order pixel.
REQ-010 o_data1 / o_data2 / o_data3  out  NB_PIX each  signed column triple: rows r-2, r-1, r at current column.
REQ-011 o_en_conv  out  1  triple valid; drives conv stage shift/accumulate enable.
REQ-012 o_win_valid  out  1  triple completes a full 3x3 window (column >= 2).
REQ-013 o_eof  out  1  one-cycle pulse with the last triple of the frame.

Function
REQ-014 FSM states: IDLE, FILL, STREAM; 2-bit encoding.
REQ-015 IDLE -> FILL on i_valid & i_sof; i_valid without i_sof in IDLE SHALL be discarded.
REQ-016 FILL -> STREAM when the row counter advances from 1 to 2; STREAM -> IDLE after the last pixel of row IMG_HEIGHT-1.
REQ-017 Column counter SHALL increment per accepted pixel and wrap IMG_WIDTH-1 -> 0, incrementing the row counter.
REQ-018 Two circular line memories (IMG_WIDTH x NB_PIX) SHALL hold rows r-1 and r-2; per accepted pixel, read-before-write at address = column.
REQ-019 Outputs SHALL be registered; latency i_pixel -> o_data3 exactly 1 cycle.
REQ-020 o_en_conv SHALL be 1 only in the cycle after an accepted pixel in STREAM; o_data* hold their last value otherwise.
REQ-021 o_win_valid = o_en_conv AND (emitted column >= 2).
REQ-022 i_valid low SHALL stall counters, memories and FSM with no loss.
REQ-023 i_sof & i_valid in FILL or STREAM SHALL restart the frame: pixel becomes row 0 col 0, state FILL, memories not cleared (stale content never emitted).
REQ-024 o_eof SHALL coincide with the o_en_conv of row IMG_HEIGHT-1, column IMG_WIDTH-1.

Reset
REQ-025 On i_nrst low: state IDLE, counters 0, all outputs 0; memories need not be cleared.
REQ-026 Reset mid-frame SHALL abort the frame; the next frame requires i_sof.

Configuration
REQ-027 Macro CONV_LINEBUF_TOP_PAD_EN: when defined, rows 0 and 1 SHALL be emitted (o_en_conv asserted) with missing upper rows forced to 0, giving IMG_HEIGHT output rows; when undefined, rows 0-1 are not emitted, giving IMG_HEIGHT-2 output rows.

Structure
REQ-028 Package conv_pkg SHALL hold NB_PIX default, IMG_WIDTH/IMG_HEIGHT defaults, FSM state constants and the counter-width function (clog2).
REQ-029 Sub-module conv_line_ram (single-clock, read-before-write, one instance per line) SHALL implement each line memory.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = 10*row+col)
REQ-030 Continuous frame, macro off -> 8 triples; row 2 col 1 emits (1,11,21), o_win_valid first at (2,2) = (2,12,22); o_eof with (13,23,33).
REQ-031 Same frame, macro on -> 16 triples; row 0 col 3 emits (0,0,3); row 1 col 0 emits (0,0,10).
REQ-032 i_valid toggled 1-0 on row 2 -> identical triple sequence as REQ-030, each 1 cycle after its accepted pixel.
REQ-033 i_sof reasserted at row 2 col 1 -> FSM to FILL, no o_en_conv until new row 2, no pre-restart values emitted.
REQ-034 i_nrst pulsed low at row 3 col 2 -> outputs 0 immediately, state IDLE, pixels without i_sof ignored.
REQ-035 i_valid without i_sof after reset -> no o_en_conv, counters stay 0.
